voice_scheduler: RTL and testbench

//  Shares NUM_SLOTS square-wave voice generators among NUM_KEYS piano keys and

---
 rtl/voice_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_voice_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// Voice allocator and sample sequencer: shares NUM_SLOTS square-wave voices among
// NUM_KEYS keys and writes one mixed sample every SAMPLE_DIV clocks to the DAC FIFO.
module voice_scheduler #(
    parameter int NUM_KEYS      = 8,
    parameter int NUM_SLOTS     = 4,
    parameter int SAMPLE_DIV    = 1042,
    parameter int AMP_PER_VOICE = 500000000,
    parameter logic [NUM_KEYS*32-1:0] HALF_PERIODS = {
        32'd47892, 32'd50619, 32'd56818, 32'd63776,
        32'd71633, 32'd76012, 32'd85324, 32'd95785}
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_KEYS-1:0]        key_play,
    input  logic                       audio_out_allowed,
    output logic [31:0]                audio_out,
    output logic                       write_audio_out,
    output logic                       clear_audio_out_memory,
    output logic [$clog2(NUM_SLOTS):0] active_voices,
    output logic                       voices_full,
    output logic                       overrun
);
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int AW = $clog2(NUM_SLOTS) + 1;
    localparam int TW = $clog2(SAMPLE_DIV + 1);
    localparam logic [TW-1:0] TICK_RELOAD = TW'(SAMPLE_DIV - 1);
    localparam logic [31:0]   AMP         = 32'(AMP_PER_VOICE);
    localparam logic [31:0]   NEG_AMP     = 32'd0 - AMP;
    localparam logic [AW-1:0] FULL_COUNT  = AW'(NUM_SLOTS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    logic [31:0]          hp_table_s [NUM_KEYS];
    logic [NUM_SLOTS-1:0] valid_r, valid_nxt_s, phase_r, phase_nxt_s;
    logic [KW-1:0]        key_r [NUM_SLOTS];
    logic [KW-1:0]        key_nxt_s [NUM_SLOTS];
    logic [31:0]          cnt_r [NUM_SLOTS];
    logic [31:0]          cnt_nxt_s [NUM_SLOTS];
    logic [NUM_KEYS-1:0]  owned_s, cand_s;
    logic [KW-1:0]        key_sel_s;
    logic [SW-1:0]        slot_sel_s;
    logic                 alloc_s;
    logic [AW-1:0]        active_nxt_s;
    logic [31:0]          mix_s;
    logic [TW-1:0]        tick_cnt_r;
    logic                 tick_s;
    state_t               state_r, state_nxt_s;
    logic                 latch_en_s, write_nxt_s, overrun_nxt_s;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_hp
        assign hp_table_s[k] = HALF_PERIODS[32*k +: 32];
    end

    // Release, single allocation per cycle and voice tone counters
    always_comb begin
        owned_s      = '0;
        key_sel_s    = '0;
        slot_sel_s   = '0;
        active_nxt_s = '0;
        mix_s        = 32'd0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            owned_s[key_r[s]] = owned_s[key_r[s]] | valid_r[s];
            mix_s = mix_s + (valid_r[s] ? (phase_r[s] ? AMP : NEG_AMP) : 32'd0);
        end
        cand_s = key_play & ~owned_s;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            key_sel_s = cand_s[k] ? KW'(k) : key_sel_s;
        end
        // Slots freed this cycle stay unavailable until the next one
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            slot_sel_s = !valid_r[s] ? SW'(s) : slot_sel_s;
        end
        alloc_s = (|cand_s) && !(&valid_r);
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (valid_r[s] && key_play[key_r[s]]) begin
                valid_nxt_s[s] = 1'b1;
                key_nxt_s[s]   = key_r[s];
                if (cnt_r[s] == 32'd1) begin
                    cnt_nxt_s[s]   = hp_table_s[key_r[s]];
                    phase_nxt_s[s] = ~phase_r[s];
                end else begin
                    cnt_nxt_s[s]   = cnt_r[s] - 32'd1;
                    phase_nxt_s[s] = phase_r[s];
                end
            end else if (alloc_s && (slot_sel_s == SW'(s))) begin
                valid_nxt_s[s] = 1'b1;
                key_nxt_s[s]   = key_sel_s;
                cnt_nxt_s[s]   = hp_table_s[key_sel_s];
                phase_nxt_s[s] = 1'b1;
            end else begin
                valid_nxt_s[s] = 1'b0;
                key_nxt_s[s]   = key_r[s];
                cnt_nxt_s[s]   = cnt_r[s];
                phase_nxt_s[s] = 1'b0;
            end
            active_nxt_s = active_nxt_s + AW'(valid_nxt_s[s]);
        end
    end

    // Slot state registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_r <= '0;
            phase_r <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                key_r[s] <= '0;
                cnt_r[s] <= 32'd0;
            end
        end else begin
            valid_r <= valid_nxt_s;
            phase_r <= phase_nxt_s;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                key_r[s] <= key_nxt_s[s];
                cnt_r[s] <= cnt_nxt_s[s];
            end
        end
    end

    assign tick_s = (tick_cnt_r == '0);

    // Sample-rate divider
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_r <= TICK_RELOAD;
        end else if (tick_s) begin
            tick_cnt_r <= TICK_RELOAD;
        end else begin
            tick_cnt_r <= tick_cnt_r - TW'(1);
        end
    end

    // Sample FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sample FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    state_nxt_s = ST_LATCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LATCH: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (audio_out_allowed) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WRITE: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Sample FSM output decode (registered below)
    always_comb begin
        latch_en_s    = (state_r == ST_IDLE) && tick_s;
        write_nxt_s   = (state_nxt_s == ST_WRITE);
        overrun_nxt_s = tick_s && (state_r != ST_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            audio_out              <= 32'd0;
            write_audio_out        <= 1'b0;
            clear_audio_out_memory <= 1'b0;
            active_voices          <= '0;
            voices_full            <= 1'b0;
            overrun                <= 1'b0;
        end else begin
            if (latch_en_s) begin
                audio_out <= mix_s;
            end else begin
                audio_out <= audio_out;
            end
            write_audio_out        <= write_nxt_s;
            clear_audio_out_memory <= (active_voices != '0) && (active_nxt_s == '0);
            active_voices          <= active_nxt_s;
            voices_full            <= (active_nxt_s == FULL_COUNT);
            overrun                <= overrun_nxt_s;
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized bench for voice_scheduler: a slot-list reference model predicts every
// registered output, and latched samples go through a scoreboard consumed on write strobes.
module tb_voice_scheduler;
    localparam int NK = 8;
    localparam int NS = 4;
    localparam int SDIV = 16;
    localparam logic [31:0] AMP32 = 32'd500000000;
    localparam logic [255:0] HP = {32'd11, 32'd10, 32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4};

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  key_play = 8'hFF;
    logic        audio_out_allowed = 1'b1;
    logic [31:0] audio_out;
    logic        write_audio_out, clear_audio_out_memory, voices_full, overrun;
    logic [2:0]  active_voices;

    voice_scheduler #(
        .NUM_KEYS(NK), .NUM_SLOTS(NS), .SAMPLE_DIV(SDIV),
        .AMP_PER_VOICE(500000000), .HALF_PERIODS(HP)
    ) dut (
        .clock(clock), .resetn(resetn), .key_play(key_play),
        .audio_out_allowed(audio_out_allowed), .audio_out(audio_out),
        .write_audio_out(write_audio_out), .clear_audio_out_memory(clear_audio_out_memory),
        .active_voices(active_voices), .voices_full(voices_full), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Reference model state: a plain list of slots plus writer bookkeeping.
    bit          m_valid [NS];
    int          m_key [NS];
    int          m_cnt [NS];
    bit          m_phase [NS];
    int          m_tick = SDIV - 1;
    int          cyc = 0;
    int          m_accept = 0;
    int          m_strobe_at = -1;
    int          m_active = 0;
    bit          m_busy = 1'b0;
    logic [31:0] e_audio = 32'd0;
    bit          e_write = 1'b0, e_clear = 1'b0, e_overrun = 1'b0, e_full = 1'b0;
    int          e_active = 0;
    logic [31:0] exp_q [$];
    int          flush_to = 0;
    int          n_cmp = 0, n_fail = 0;
    bit          chk_en = 1'b0;

    always @(posedge clock) begin
        bit          tick, idle;
        int          fs, fk, count;
        logic [31:0] mix;
        bit          owned [NK];
        if (!resetn) begin
            for (int s = 0; s < NS; s++) begin
                m_valid[s] = 1'b0; m_phase[s] = 1'b0; m_cnt[s] = 0; m_key[s] = 0;
            end
            m_tick = SDIV - 1; m_busy = 1'b0; m_strobe_at = -1; m_active = 0;
            e_audio = 32'd0; e_write = 1'b0; e_clear = 1'b0; e_overrun = 1'b0;
            e_full = 1'b0; e_active = 0;
            flush_to = exp_q.size();
        end else begin
            cyc = cyc + 1;
            tick = (m_tick == 0);
            m_tick = tick ? SDIV - 1 : m_tick - 1;
            mix = 32'd0;
            for (int s = 0; s < NS; s++) begin
                if (m_valid[s]) mix = m_phase[s] ? mix + AMP32 : mix - AMP32;
            end
            // Writer: sample accepted on an idle tick, strobed once allowed from 2 edges later,
            // and busy through the edge after the strobe.
            e_write = 1'b0; e_overrun = 1'b0;
            idle = !m_busy;
            if (m_busy) begin
                if (m_strobe_at >= 0) begin
                    if (cyc == m_strobe_at + 1) m_busy = 1'b0;
                end else if (cyc >= m_accept + 2 && audio_out_allowed) begin
                    m_strobe_at = cyc; e_write = 1'b1;
                end
            end
            if (tick) begin
                if (idle) begin
                    m_busy = 1'b1; m_accept = cyc; m_strobe_at = -1;
                    e_audio = mix; exp_q.push_back(mix);
                end else begin
                    e_overrun = 1'b1;
                end
            end
            for (int k = 0; k < NK; k++) owned[k] = 1'b0;
            for (int s = 0; s < NS; s++) if (m_valid[s]) owned[m_key[s]] = 1'b1;
            fk = -1;
            for (int k = NK - 1; k >= 0; k--) if (key_play[k] && !owned[k]) fk = k;
            fs = -1;
            for (int s = NS - 1; s >= 0; s--) if (!m_valid[s]) fs = s;
            count = 0;
            for (int s = 0; s < NS; s++) begin
                if (m_valid[s] && key_play[m_key[s]]) begin
                    if (m_cnt[s] == 1) begin
                        m_cnt[s] = 4 + m_key[s]; m_phase[s] = !m_phase[s];
                    end else begin
                        m_cnt[s] = m_cnt[s] - 1;
                    end
                end else if (!m_valid[s] && s == fs && fk >= 0) begin
                    m_valid[s] = 1'b1; m_key[s] = fk; m_cnt[s] = 4 + fk; m_phase[s] = 1'b1;
                end else begin
                    m_valid[s] = 1'b0;
                end
                if (m_valid[s]) count = count + 1;
            end
            e_clear = (m_active != 0) && (count == 0);
            e_active = count;
            e_full = (count == NS);
            m_active = count;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp = n_cmp + 1;
        if (act !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: per-cycle output checks and scoreboard consumption on each write strobe.
    int rd_idx = 0;
    always @(negedge clock) begin
        if (chk_en) begin
            check("audio_out", audio_out, e_audio);
            check("write_strobe", 32'(write_audio_out), 32'(e_write));
            check("clear_pulse", 32'(clear_audio_out_memory), 32'(e_clear));
            check("overrun", 32'(overrun), 32'(e_overrun));
            check("active_voices", 32'(active_voices), 32'(e_active));
            check("voices_full", 32'(voices_full), 32'(e_full));
            if (write_audio_out) begin
                if (rd_idx < flush_to) rd_idx = flush_to;
                if (rd_idx >= exp_q.size()) begin
                    n_cmp = n_cmp + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL sample_scoreboard at cycle %0d: strobe with value %0d, expected no pending sample", cyc, audio_out);
                end else begin
                    check("sample_value", audio_out, exp_q[rd_idx]);
                    rd_idx = rd_idx + 1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    initial begin
        @(posedge clock);
        #1 chk_en = 1'b1;
        cycles(3);
        resetn = 1'b1;                 // all keys held: slots fill 0..3
        cycles(12);
        key_play = 8'h01;              // single tone
        cycles(40);
        key_play = 8'h1F;              // key 4 waits for a slot
        cycles(10);
        key_play = 8'h1D;              // key 1 released, key 4 takes its slot
        cycles(10);
        audio_out_allowed = 1'b0;      // backpressure
        cycles(20);
        audio_out_allowed = 1'b1;
        cycles(10);
        key_play = 8'h03;              // two-voice mix
        cycles(40);
        key_play = 8'h00;              // silence
        cycles(20);
        key_play = 8'h07;              // reset while a sample waits for the FIFO
        audio_out_allowed = 1'b0;
        cycles(18);
        resetn = 1'b0;
        cycles(2);
        resetn = 1'b1;
        audio_out_allowed = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i % 8 == 0) key_play = 8'($urandom_range(0, 255));
            if (i % 5 == 0) audio_out_allowed = ($urandom_range(0, 3) != 0);
            if (i == 400) resetn = 1'b0;
            if (i == 402) resetn = 1'b1;
            cycles(1);
        end
        key_play = 8'h00;
        audio_out_allowed = 1'b1;
        cycles(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
